// File: rtl/reg_ul_access_mc.sv
// Multi-channel user-logic register bank on the CPU MPI bus: version/test regs, pipelined adder,
// sticky W1C error flags, clear-on-read event counters. Define ERR_IRQ_EN for the error mask and interrupt.
module reg_ul_access_mc #(
   parameter int CPU_ADDR_WIDTH = 12,
   parameter int CPU_DATA_WIDTH = 32,
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 16,
   parameter int ADD_PIPE       = 2,
   parameter logic [CPU_DATA_WIDTH-1:0] VER_TIME = 32'h2018_0901,
   parameter logic [CPU_DATA_WIDTH-1:0] VER_TYPE = 32'h00D3_0009
) (
   input  logic                      clks,
   input  logic                      reset,
   input  logic                      cpu_wr,
   input  logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
   input  logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
   input  logic                      cpu_rd,
   output logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
   output logic                      cpu_rd_vld,
   input  logic [NUM_CH-1:0]         ch_err,
   input  logic [NUM_CH-1:0]         ch_evt,
   output logic [15:0]               ul2sh_vled,
   output logic                      irq_out
);

   localparam logic [11:0] A_VER_TIME = 12'h000;
   localparam logic [11:0] A_VER_TYPE = 12'h001;
   localparam logic [11:0] A_SCRATCH  = 12'h002;
   localparam logic [11:0] A_OP_A     = 12'h003;
   localparam logic [11:0] A_OP_B     = 12'h004;
   localparam logic [11:0] A_SUM      = 12'h005;
   localparam logic [11:0] A_CARRY    = 12'h006;
   localparam logic [11:0] A_VLED     = 12'h007;
   localparam logic [11:0] A_ERR      = 12'h008;
   localparam logic [11:0] A_MASK     = 12'h009;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [11:0]               addr;
   logic [CPU_DATA_WIDTH-1:0] scratch;
   logic [CPU_DATA_WIDTH-1:0] op_a;
   logic [CPU_DATA_WIDTH-1:0] op_b;
   logic [15:0]               vled;
   logic [NUM_CH-1:0]         err_sticky;
   logic [NUM_CH-1:0]         err_clr;
   logic [CPU_DATA_WIDTH:0]   add_pipe [ADD_PIPE];
   logic [CPU_DATA_WIDTH:0]   sum_q;
   logic [CNT_W-1:0]          cnt [NUM_CH];
   logic [CPU_DATA_WIDTH-1:0] rd_data;

   assign addr       = cpu_wr_addr[11:0];
   assign sum_q      = add_pipe[ADD_PIPE-1];
   assign ul2sh_vled = vled;

   always_ff @(posedge clks) begin
      if (reset) begin
         scratch <= '0;
         op_a    <= '0;
         op_b    <= '0;
         vled    <= '0;
      end else if (cpu_wr) begin
         case (addr)
            A_SCRATCH: scratch <= cpu_data_in;
            A_OP_A:    op_a    <= cpu_data_in;
            A_OP_B:    op_b    <= cpu_data_in;
            A_VLED:    vled    <= cpu_data_in[15:0];
            default:   ;
         endcase
      end
   end

   // Stage 0 adds the operand registers, so the result lands ADD_PIPE edges after an operand write.
   always_ff @(posedge clks) begin
      if (reset) begin
         for (int i = 0; i < ADD_PIPE; i++) add_pipe[i] <= '0;
      end else begin
         add_pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
         for (int i = 1; i < ADD_PIPE; i++) add_pipe[i] <= add_pipe[i-1];
      end
   end

   assign err_clr = (cpu_wr && addr == A_ERR) ? cpu_data_in[NUM_CH-1:0] : '0;

   // A new error in the same cycle as its W1C clear wins.
   always_ff @(posedge clks) begin
      if (reset) err_sticky <= '0;
      else       err_sticky <= (err_sticky & ~err_clr) | ch_err;
   end

`ifdef ERR_IRQ_EN
   logic [NUM_CH-1:0] err_mask;

   always_ff @(posedge clks) begin
      if (reset) begin
         err_mask <= '1;
         irq_out  <= 1'b0;
      end else begin
         if (cpu_wr && addr == A_MASK) err_mask <= cpu_data_in[NUM_CH-1:0];
         irq_out <= |(err_sticky & ~err_mask);
      end
   end
`else
   assign irq_out = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      localparam logic [11:0] CNT_ADDR = 12'(16 + g);
      logic [CNT_W-1:0] cnt_q;

      // The clearing read returns the pre-clear value; a coincident event restarts the count at 1.
      always_ff @(posedge clks) begin
         if (reset)
            cnt_q <= '0;
         else if (cpu_rd && addr == CNT_ADDR)
            cnt_q <= ch_evt[g] ? CNT_W'(1) : '0;
         else if (ch_evt[g] && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_W'(1);
      end

      assign cnt[g] = cnt_q;
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         A_VER_TIME: rd_data = VER_TIME;
         A_VER_TYPE: rd_data = VER_TYPE;
         A_SCRATCH:  rd_data = ~scratch;
         A_OP_A:     rd_data = op_a;
         A_OP_B:     rd_data = op_b;
         A_SUM:      rd_data = sum_q[CPU_DATA_WIDTH-1:0];
         A_CARRY:    rd_data[0] = sum_q[CPU_DATA_WIDTH];
         A_VLED:     rd_data[15:0] = vled;
         A_ERR:      rd_data[NUM_CH-1:0] = err_sticky;
`ifdef ERR_IRQ_EN
         A_MASK:     rd_data[NUM_CH-1:0] = err_mask;
`endif
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (addr == 12'(16 + i)) rd_data[CNT_W-1:0] = cnt[i];
            end
         end
      endcase
   end

   always_ff @(posedge clks) begin
      if (reset) begin
         cpu_data_out <= '0;
         cpu_rd_vld   <= 1'b0;
      end else begin
         cpu_rd_vld <= cpu_rd;
         if (cpu_rd) cpu_data_out <= rd_data;
      end
   end

endmodule

// File: tb/tb_reg_ul_access_mc.sv
// Self-checking bench for reg_ul_access_mc: table of directed bus accesses plus hand-written
// sequences for adder latency, counter saturation/clear-on-read, W1C races, interrupt and reset-during-read.
module tb_reg_ul_access_mc;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;

   logic        clks;
   logic        reset;
   logic        cpu_wr;
   logic [11:0] cpu_wr_addr;
   logic [31:0] cpu_data_in;
   logic        cpu_rd;
   logic [31:0] cpu_data_out;
   logic        cpu_rd_vld;
   logic [3:0]  ch_err;
   logic [3:0]  ch_evt;
   logic [15:0] ul2sh_vled;
   logic        irq_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        wr;
      logic        rd;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  err;
      logic [3:0]  evt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   reg_ul_access_mc #(
      .CPU_ADDR_WIDTH(12),
      .CPU_DATA_WIDTH(32),
      .NUM_CH(NUM_CH),
      .CNT_W(CNT_W),
      .ADD_PIPE(2)
   ) dut (
      .clks(clks),
      .reset(reset),
      .cpu_wr(cpu_wr),
      .cpu_wr_addr(cpu_wr_addr),
      .cpu_data_in(cpu_data_in),
      .cpu_rd(cpu_rd),
      .cpu_data_out(cpu_data_out),
      .cpu_rd_vld(cpu_rd_vld),
      .ch_err(ch_err),
      .ch_evt(ch_evt),
      .ul2sh_vled(ul2sh_vled),
      .irq_out(irq_out)
   );

   initial begin
      clks = 1'b0;
      forever #5 clks = ~clks;
   end

   function automatic vec_t mk(input string n, input logic wr, input logic rd, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] e, input logic [3:0] v,
                               input logic [31:0] x);
      vec_t t;
      t.name = n; t.wr = wr; t.rd = rd; t.addr = a; t.data = d; t.err = e; t.evt = v; t.exp = x;
      return t;
   endfunction

   // One bus cycle: drive on the falling edge, let the rising edge act, settle, then release.
   task automatic applyStimulus(input vec_t v);
      @(negedge clks);
      cpu_wr      = v.wr;
      cpu_rd      = v.rd;
      cpu_wr_addr = v.addr;
      cpu_data_in = v.data;
      ch_err      = v.err;
      ch_evt      = v.evt;
      @(posedge clks);
      #1;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      ch_err = '0;
      ch_evt = '0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic checkRead(input string name, input logic [31:0] exp);
      checkOutput({name, "_vld"}, {31'b0, cpu_rd_vld}, 32'd1);
      checkOutput(name, cpu_data_out, exp);
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      applyStimulus(mk(name, 1'b0, 1'b1, a, 32'h0, 4'h0, 4'h0, exp));
      checkRead(name, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      applyStimulus(mk("wr", 1'b1, 1'b0, a, d, 4'h0, 4'h0, 32'h0));
   endtask

   task automatic idle();
      applyStimulus(mk("idle", 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 4'h0, 32'h0));
   endtask

   initial begin
      reset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wr_addr = '0; cpu_data_in = '0;
      ch_err = '0; ch_evt = '0;

      vecs.push_back(mk("ver_time",     0, 1, 12'h000, 32'h0,         4'h0, 4'h0, 32'h2018_0901));
      vecs.push_back(mk("ver_type",     0, 1, 12'h001, 32'h0,         4'h0, 4'h0, 32'h00D3_0009));
      vecs.push_back(mk("unmapped_00f", 0, 1, 12'h00F, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("scratch_rst",  0, 1, 12'h002, 32'h0,         4'h0, 4'h0, 32'hFFFF_FFFF));
      vecs.push_back(mk("wr_scratch",   1, 0, 12'h002, 32'h1234_5678, 4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("scratch_inv",  0, 1, 12'h002, 32'h0,         4'h0, 4'h0, 32'hEDCB_A987));
      vecs.push_back(mk("wr_vled",      1, 0, 12'h007, 32'hFFFF_0055, 4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("vled_rd",      0, 1, 12'h007, 32'h0,         4'h0, 4'h0, 32'h0000_0055));
      vecs.push_back(mk("err_rst",      0, 1, 12'h008, 32'h0,         4'h0, 4'h0, 32'h0));
`ifdef ERR_IRQ_EN
      vecs.push_back(mk("mask_rst",     0, 1, 12'h009, 32'h0,         4'h0, 4'h0, 32'h0000_000F));
`else
      vecs.push_back(mk("wr_mask",      1, 0, 12'h009, 32'h0000_0005, 4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("mask_absent",  0, 1, 12'h009, 32'h0,         4'h0, 4'h0, 32'h0));
`endif
      vecs.push_back(mk("wr_sum_ro",    1, 0, 12'h005, 32'hDEAD_BEEF, 4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("sum_rst",      0, 1, 12'h005, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("carry_rst",    0, 1, 12'h006, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("wr_unmapped",  1, 0, 12'h00A, 32'h0000_1234, 4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("unmapped_00a", 0, 1, 12'h00A, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("unmapped_0ff", 0, 1, 12'h0FF, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("cnt0_rst",     0, 1, 12'h010, 32'h0,         4'h0, 4'h0, 32'h0));
      vecs.push_back(mk("cnt_beyond",   0, 1, 12'h014, 32'h0,         4'h0, 4'h0, 32'h0));

      repeat (3) @(posedge clks);
      #1;
      checkOutput("rst_data_out", cpu_data_out, 32'h0);
      checkOutput("rst_rd_vld", {31'b0, cpu_rd_vld}, 32'h0);
      checkOutput("rst_vled", {16'b0, ul2sh_vled}, 32'h0);
      checkOutput("rst_irq", {31'b0, irq_out}, 32'h0);
      @(negedge clks);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         if (vecs[i].rd) checkRead(vecs[i].name, vecs[i].exp);
      end
      checkOutput("vled_port", {16'b0, ul2sh_vled}, 32'h0000_0055);

      // Read data holds and the valid strobe is a single pulse.
      rd("ver_time_again", 12'h000, 32'h2018_0901);
      idle();
      checkOutput("vld_pulse", {31'b0, cpu_rd_vld}, 32'h0);
      checkOutput("data_hold", cpu_data_out, 32'h2018_0901);

      // Simultaneous write and read of scratch returns the old value.
      applyStimulus(mk("wr_rd_same", 1, 1, 12'h002, 32'hFFFF_0000, 4'h0, 4'h0, 32'h0));
      checkRead("wr_rd_same", 32'hEDCB_A987);
      rd("scratch_new", 12'h002, 32'h0000_FFFF);

      // Adder latency: new sum visible on the third cycle after the op_a write.
      wr(12'h004, 32'h0000_0002);
      repeat (4) idle();
      wr(12'h003, 32'hFFFF_FFFF);
      rd("sum_old_1", 12'h005, 32'h0000_0002);
      rd("sum_old_2", 12'h005, 32'h0000_0002);
      rd("sum_new", 12'h005, 32'h0000_0001);
      rd("carry_new", 12'h006, 32'h0000_0001);
      rd("op_a_rd", 12'h003, 32'hFFFF_FFFF);

      // Event counters: count, clear-on-read, saturation, coincident event.
      repeat (5) applyStimulus(mk("evt1", 0, 0, 12'h0, 32'h0, 4'h0, 4'h2, 32'h0));
      rd("cnt1_five", 12'h011, 32'h5);
      rd("cnt1_cleared", 12'h011, 32'h0);
      rd("cnt0_untouched", 12'h010, 32'h0);
      repeat (20) applyStimulus(mk("evt1", 0, 0, 12'h0, 32'h0, 4'h0, 4'h2, 32'h0));
      rd("cnt1_sat", 12'h011, 32'hF);
      repeat (3) applyStimulus(mk("evt1", 0, 0, 12'h0, 32'h0, 4'h0, 4'h2, 32'h0));
      applyStimulus(mk("cnt1_coinc", 0, 1, 12'h011, 32'h0, 4'h0, 4'h2, 32'h0));
      checkRead("cnt1_coinc", 32'h3);
      rd("cnt1_after_coinc", 12'h011, 32'h1);

      // Sticky W1C error flags.
      applyStimulus(mk("err2", 0, 0, 12'h0, 32'h0, 4'h4, 4'h0, 32'h0));
      rd("err_set", 12'h008, 32'h4);
      wr(12'h008, 32'h0);
      rd("err_w0", 12'h008, 32'h4);
      applyStimulus(mk("w1c_race", 1, 0, 12'h008, 32'h4, 4'h4, 4'h0, 32'h0));
      rd("err_set_wins", 12'h008, 32'h4);
      wr(12'h008, 32'h4);
      rd("err_cleared", 12'h008, 32'h0);

`ifdef ERR_IRQ_EN
      wr(12'h009, 32'h0);
      rd("mask_zero", 12'h009, 32'h0);
      applyStimulus(mk("err0", 0, 0, 12'h0, 32'h0, 4'h1, 4'h0, 32'h0));
      checkOutput("irq_not_yet", {31'b0, irq_out}, 32'h0);
      idle();
      checkOutput("irq_set", {31'b0, irq_out}, 32'h1);
      wr(12'h009, 32'h1);
      idle();
      checkOutput("irq_masked", {31'b0, irq_out}, 32'h0);
      wr(12'h008, 32'h1);
`else
      applyStimulus(mk("err0", 0, 0, 12'h0, 32'h0, 4'h1, 4'h0, 32'h0));
      idle();
      idle();
      checkOutput("irq_tied_low", {31'b0, irq_out}, 32'h0);
      rd("err0_set", 12'h008, 32'h1);
`endif

      // Reset during a read drops it and returns everything to reset values.
      applyStimulus(mk("evt0", 0, 0, 12'h0, 32'h0, 4'h0, 4'h1, 32'h0));
      rd("pre_reset", 12'h000, 32'h2018_0901);
      @(negedge clks);
      reset = 1'b1; cpu_rd = 1'b1; cpu_wr_addr = 12'h010;
      @(posedge clks);
      #1;
      cpu_rd = 1'b0;
      checkOutput("rst_read_vld", {31'b0, cpu_rd_vld}, 32'h0);
      checkOutput("rst_read_data", cpu_data_out, 32'h0);
      checkOutput("rst_vled_again", {16'b0, ul2sh_vled}, 32'h0);
      @(negedge clks);
      reset = 1'b0;
      rd("scratch_after_rst", 12'h002, 32'hFFFF_FFFF);
      rd("cnt0_after_rst", 12'h010, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_ul_access_mc.md
Name: reg_ul_access_mc

Overview:
Parametrised user-logic register bank on the CPU MPI bus, successor to the single-channel UL access block.
- Version and test registers, plus a pipelined adder with carry out.
- Per-channel sticky write-1-to-clear (W1C) error flags.
- Per-channel saturating event counters, clear-on-read.
- Registered read data with an explicit read-valid strobe.

Sits between the shell MPI bridge and the user datapath channels.

Parameters:
CPU_ADDR_WIDTH, 12, address width; decode uses bits [11:0]
CPU_DATA_WIDTH, 32, data width
NUM_CH, 4, number of monitored channels, 1..16
CNT_W, 16, event counter width, 1..CPU_DATA_WIDTH
ADD_PIPE, 2, adder pipeline stages, 1..4
VER_TIME, 32'h2018_0901, version date constant
VER_TYPE, 32'h00D3_0009, version type constant

Ports:
clks  in  1  clock
reset  in  1  synchronous active-high reset
cpu_wr  in  1  write strobe, one cycle per access
cpu_wr_addr  in  CPU_ADDR_WIDTH  shared read/write address
cpu_data_in  in  CPU_DATA_WIDTH  write data
cpu_rd  in  1  read strobe, one cycle per access
cpu_data_out  out  CPU_DATA_WIDTH  registered read data
cpu_rd_vld  out  1  read data valid pulse
ch_err  in  NUM_CH  per-channel error pulse
ch_evt  in  NUM_CH  per-channel event pulse
ul2sh_vled  out  16  virtual LED register
irq_out  out  1  level interrupt

Behaviour:
- One clock (clks); reset is synchronous and active-high. All state is sampled on the clks edge when reset=1.
- Reset values:
  - cpu_data_out=0, cpu_rd_vld=0, ul2sh_vled=0, irq_out=0
  - All config registers 0, except mask = all ones.
  - Counters, error flags and adder pipeline 0.
- Address map (word addresses):
  - 0x000 VER_TIME (RO)
  - 0x001 VER_TYPE (RO)
  - 0x002 scratch (RW); reads return the bitwise inverse of the stored value
  - 0x003 op_a (RW)
  - 0x004 op_b (RW)
  - 0x005 sum[CPU_DATA_WIDTH-1:0] (RO)
  - 0x006 sum carry, bit 0 (RO)
  - 0x007 vled (RW, bits [15:0]; upper bits read 0)
  - 0x008 err_sticky (W1C, NUM_CH bits)
  - 0x009 err_mask (RW, NUM_CH bits)
  - 0x010+ch event counter ch (RO, clear-on-read), ch = 0..NUM_CH-1
  - Unmapped addresses read 0; writes to them are ignored.
- Read timing:
  - cpu_rd at cycle T with address A → cpu_data_out holds the value of A as of T, and cpu_rd_vld=1, both at T+1.
  - cpu_data_out holds its value until the next read. cpu_rd_vld is a single-cycle pulse.
- Writes take effect at the edge ending the cpu_wr cycle.
- Write and read to the same address in the same cycle: the read returns the old value.
- Adder:
  - Computes {carry, sum} = op_a + op_b at CPU_DATA_WIDTH+1 bits.
  - The result appears at 0x005/0x006 exactly ADD_PIPE cycles after the operand register update.
  - The pipeline runs continuously; there is no enable.
- err_sticky:
  - A bit sets on ch_err[i]=1.
  - Writing 1 to a bit clears it; writing 0 has no effect.
  - Set and clear in the same cycle: set wins, bit stays 1.
- Event counters:
  - Increment by 1 on ch_evt[i]=1.
  - Saturate at 2^CNT_W-1 with no wrap. Read data is zero-extended.
  - Clear-on-read: a cpu_rd to 0x010+i clears counter i at the edge ending that cpu_rd cycle, and the pre-clear value is returned.
  - An event in the same cycle as the clearing read → counter = 1 after the edge. That event is not included in the returned value.
- Reset asserted mid-read: cpu_rd_vld=0 next cycle and the pending read is dropped. No counter clear occurs for a read in a cycle with reset=1.
- cpu_wr and cpu_rd in the same cycle are both serviced.

Optional Feature:
ERR_IRQ_EN
- Defined: irq_out is a registered |(err_sticky & ~err_mask), asserted one cycle after the sticky bit or mask change. 0x009 behaves as RW.
- Undefined:
  - irq_out is tied 0.
  - 0x009 reads 0 and writes are ignored.
  - No mask register is instantiated.

Test Plan:
- Reset, then read 0x000, 0x001 → cpu_rd_vld pulses 1 cycle after each cpu_rd; data 32'h2018_0901, 32'h00D3_0009. Read 0x00F → 0.
- Write 0x002 = 32'h1234_5678, read back → 32'hEDCB_A987. Write 0x007 = 32'hFFFF_0055 → ul2sh_vled=16'h0055 and readback 32'h0000_0055.
- op_a = 32'hFFFF_FFFF, op_b = 32'h0000_0002, wait ADD_PIPE cycles → 0x005 = 32'h0000_0001, 0x006 = 1. Reading before ADD_PIPE cycles → old sum.
- Pulse ch_evt[1] 5 times, read 0x011 → 5, re-read → 0. With CNT_W=4, 20 events → 15. Event coincident with the clearing read → next read 1.
- ch_err[2] pulse → 0x008 = 4. Write 0x008 = 4 while ch_err[2]=1 → stays 4. Write again with no error → 0.
- With ERR_IRQ_EN: mask = 0, ch_err[0] pulse → irq_out=1 next cycle; mask = 1 → irq_out=0. Without ERR_IRQ_EN: irq_out stays 0 and 0x009 reads 0.
